// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin fifo drain scheduler.
package fifo_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } sched_state_e;

    // Number of bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: first requesting index strictly after last_grant_i, wrapping modulo N.
module rr_next_sel
    import fifo_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins the final write.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        idx_o = last_grant_i;
        any_o = 1'b0;
        cand  = last_grant_i;
        for (int k = N; k >= 1; k--) begin
            cand = last_grant_i + IDX_W'(k);
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains NUM_FIFO upstream fifos round-robin in bursts into a 3-entry credit-controlled
// output buffer; fifo data_out is registered, so each pop is captured one cycle later.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NUM_FIFO   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_FIFO-1:0]            fifo_empty,
    output logic [NUM_FIFO-1:0]            fifo_pop,
    input  logic [NUM_FIFO*DATA_WIDTH-1:0] fifo_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [clog2(NUM_FIFO)-1:0]     m_src,
    output logic                           busy
);

    localparam int IDX_W  = clog2(NUM_FIFO);
    localparam int BCNT_W = clog2(BURST_LEN + 1);
    localparam int DEPTH  = 3;

    sched_state_e          state_q, state_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [BCNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic                  pop_pending_q;
    logic [IDX_W-1:0]      pop_src_q;
    logic [1:0]            buf_count_q, buf_count_d;
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [IDX_W-1:0]      buf_src_q  [DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];

    logic [NUM_FIFO-1:0]   fifo_req;
    logic [IDX_W-1:0]      rr_idx;
    logic                  rr_any;
    logic                  credit;
    logic                  pop_now;
    logic                  capture;
    logic                  drain;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign fifo_req = ~fifo_empty;

    rr_next_sel #(
        .N     (NUM_FIFO),
        .IDX_W (IDX_W)
    ) u_rr_next_sel (
        .req_i        (fifo_req),
        .last_grant_i (last_grant_q),
        .idx_o        (rr_idx),
        .any_o        (rr_any)
    );

    // Credit counts the in-flight pop so a full buffer can never be overrun; m_ready is not involved.
    assign credit  = ({1'b0, buf_count_q} + {2'b00, pop_pending_q}) < 3'(DEPTH);
    assign capture = pop_pending_q;
    assign drain   = m_valid && m_ready;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        pop_now      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && rr_any) begin
                    cur_d        = rr_idx;
                    last_grant_d = rr_idx;
                    burst_cnt_d  = '0;
                    state_d      = ACTIVE;
                end
            end
            ACTIVE: begin
                pop_now = !fifo_empty[cur_q] && enable && credit && !reset;
                if (pop_now) begin
                    burst_cnt_d = burst_cnt_q + BCNT_W'(1);
                end
                if (fifo_empty[cur_q] || !enable ||
                    (pop_now && burst_cnt_q == BCNT_W'(BURST_LEN - 1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop        = '0;
        fifo_pop[cur_q] = pop_now;
    end

    always_comb begin
        unique case ({capture, drain})
            2'b10:   buf_count_d = buf_count_q + 2'd1;
            2'b01:   buf_count_d = buf_count_q - 2'd1;
            default: buf_count_d = buf_count_q;
        endcase
    end

    // A capture due right after reset is dropped because pop_pending_q is cleared.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            last_grant_q  <= IDX_W'(NUM_FIFO - 1);
            burst_cnt_q   <= '0;
            pop_pending_q <= 1'b0;
            pop_src_q     <= '0;
            buf_count_q   <= 2'd0;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            last_grant_q  <= last_grant_d;
            burst_cnt_q   <= burst_cnt_d;
            pop_pending_q <= pop_now;
            pop_src_q     <= cur_q;
            buf_count_q   <= buf_count_d;
            if (capture) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (drain)   rd_ptr_q <= next_ptr(rd_ptr_q);
        end
    end

    // NOTE: buffer storage has no reset; pointers and count are reset and outputs are masked by m_valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_src_q[wr_ptr_q]  <= pop_src_q;
            buf_data_q[wr_ptr_q] <= fifo_data[int'(pop_src_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign m_valid = (buf_count_q != 2'd0);
    assign m_data  = m_valid ? buf_data_q[rd_ptr_q] : '0;
    assign m_src   = m_valid ? buf_src_q[rd_ptr_q]  : '0;
    assign busy    = (state_q != IDLE) || pop_pending_q || m_valid;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench: queue-based upstream fifos, a burst/grant-level round-robin model
// and an in-order scoreboard of popped words.
module tb_fifo_rr_scheduler;
    import fifo_sched_pkg::*;

    localparam int NUM_FIFO   = 4;
    localparam int DATA_WIDTH = 64;
    localparam int BURST_LEN  = 4;
    localparam int IDX_W      = clog2(NUM_FIFO);
    localparam int CAP        = 256;

    logic                           clk = 1'b0;
    logic                           reset = 1'b1;
    logic                           enable = 1'b0;
    logic                           m_ready = 1'b0;
    logic [NUM_FIFO-1:0]            fifo_empty;
    logic [NUM_FIFO-1:0]            fifo_pop;
    logic [NUM_FIFO*DATA_WIDTH-1:0] fifo_data;
    logic                           m_valid;
    logic [DATA_WIDTH-1:0]          m_data;
    logic [IDX_W-1:0]               m_src;
    logic                           busy;

    always #5 clk = ~clk;

    fifo_rr_scheduler #(
        .NUM_FIFO   (NUM_FIFO),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_src      (m_src),
        .busy       (busy)
    );

    typedef struct packed {
        logic [IDX_W-1:0]      src;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    logic [DATA_WIDTH-1:0] mem [NUM_FIFO][CAP];
    int                    head [NUM_FIFO];
    int                    tail [NUM_FIFO];
    word_t                 exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    int model_last;
    int burst_cnt;
    int burst_src;
    int last_burst_end;
    int phase_pops;
    int phase_xfers;
    int first_pop_cycle;
    int last_pop_cycle;
    int burst_lens[$];
    int grants[$];

    logic                  prev_stall;
    logic [DATA_WIDTH-1:0] prev_data;
    logic [IDX_W-1:0]      prev_src;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_expect(input int last);
        int c;
        for (int k = 1; k <= NUM_FIFO; k++) begin
            c = (last + k) % NUM_FIFO;
            if (head[c] != tail[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int f = 0; f < NUM_FIFO; f++) if (head[f] != tail[f]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int words_left();
        int n;
        n = 0;
        for (int f = 0; f < NUM_FIFO; f++) n += tail[f] - head[f];
        return n;
    endfunction

    task automatic fill(input int f, input int n);
        if (head[f] == tail[f]) begin
            head[f] = 0;
            tail[f] = 0;
        end
        for (int k = 0; k < n; k++) begin
            mem[f][tail[f]] = {$urandom, $urandom};
            tail[f]++;
        end
        fifo_empty[f] = (head[f] == tail[f]);
    endtask

    task automatic new_phase();
        phase_pops  = 0;
        phase_xfers = 0;
        burst_lens.delete();
        grants.delete();
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_last     = NUM_FIFO - 1;
        burst_cnt      = 0;
        last_burst_end = -1;
        prev_stall     = 1'b0;
    endtask

    // One clock: observe at the falling edge, then update upstream fifos just after the rising edge.
    task automatic step();
        int                    pi;
        logic                  pend;
        logic [DATA_WIDTH-1:0] pend_word;
        word_t                 w;
        bit                    was_reset;
        pi   = 0;
        pend = 1'b0;
        pend_word = '0;
        @(negedge clk);
        cycle++;
        was_reset = reset;
        if (reset) begin
            check("rst_pop", fifo_pop, '0);
        end else begin
            if (fifo_pop != '0) begin
                check("pop_onehot", $countones(fifo_pop), 1);
                for (int i = 0; i < NUM_FIFO; i++) if (fifo_pop[i]) pi = i;
                check("pop_nonempty", head[pi] != tail[pi], 1);
                if (head[pi] != tail[pi]) begin
                    if (burst_cnt == 0) begin
                        check("grant", pi, rr_expect(model_last));
                        if (last_burst_end >= 0) check("gap", (cycle - last_burst_end) >= 2, 1);
                        model_last = pi;
                        burst_src  = pi;
                        grants.push_back(pi);
                    end else begin
                        check("burst_src", pi, burst_src);
                    end
                    if (phase_pops == 0) first_pop_cycle = cycle;
                    last_pop_cycle = cycle;
                    phase_pops++;
                    burst_cnt++;
                    pend_word = mem[pi][head[pi]];
                    head[pi]++;
                    pend   = 1'b1;
                    w.src  = IDX_W'(pi);
                    w.data = pend_word;
                    exp_q.push_back(w);
                    if (burst_cnt == BURST_LEN || head[pi] == tail[pi]) begin
                        burst_lens.push_back(burst_cnt);
                        burst_cnt      = 0;
                        last_burst_end = cycle;
                    end
                end
            end
            if (prev_stall) check("hold", {m_valid, m_src, m_data}, {1'b1, prev_src, prev_data});
            if (m_valid && m_ready) begin
                phase_xfers++;
                if (exp_q.size() == 0) begin
                    check("xfer_extra", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("xfer_src", m_src, w.src);
                    check("xfer_data", m_data, w.data);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_src   = m_src;
            prev_data  = m_data;
        end
        @(posedge clk);
        #1;
        if (was_reset) model_reset();
        if (pend) fifo_data[pi*DATA_WIDTH +: DATA_WIDTH] = pend_word;
        for (int f = 0; f < NUM_FIFO; f++) fifo_empty[f] = (head[f] == tail[f]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic drain(input int max_cycles, input bit rand_ready);
        int n;
        n = 0;
        while (!(busy == 1'b0 && all_empty() && exp_q.size() == 0) && n < max_cycles) begin
            if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        if (n >= max_cycles) check("drain_timeout", 0, 1);
    endtask

    task automatic wait_pops(input int target, input int max_cycles);
        int n;
        n = 0;
        while (phase_pops < target && n < max_cycles) begin
            step();
            n++;
        end
        if (n >= max_cycles) check("pop_timeout", phase_pops, target);
    endtask

    initial begin
        int c1_exp[3];
        int total;
        c1_exp = '{4, 4, 2};
        fifo_empty = '1;
        fifo_data  = '0;
        for (int f = 0; f < NUM_FIFO; f++) begin
            head[f] = 0;
            tail[f] = 0;
        end
        model_reset();
        new_phase();

        // Reset state
        do_reset();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_src", m_src, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_pop", fifo_pop, 0);
        reset  = 1'b0;
        enable = 1'b1;

        // Case 1: single fifo, 10 words, bursts 4/4/2
        new_phase();
        fill(1, 10);
        m_ready = 1'b1;
        drain(400, 1'b0);
        check("c1_pops", phase_pops, 10);
        check("c1_xfers", phase_xfers, 10);
        check("c1_nbursts", burst_lens.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("c1_burst%0d", i), (i < burst_lens.size()) ? burst_lens[i] : -1, c1_exp[i]);
        check("c1_span", last_pop_cycle - first_pop_cycle + 1, 12);

        // Case 2: all fifos 8 words, round-robin from fifo 0
        do_reset();
        reset = 1'b0;
        new_phase();
        for (int f = 0; f < NUM_FIFO; f++) fill(f, 8);
        m_ready = 1'b1;
        drain(800, 1'b0);
        check("c2_pops", phase_pops, 32);
        check("c2_xfers", phase_xfers, 32);
        check("c2_ngrants", grants.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("c2_grant%0d", i), (i < grants.size()) ? grants[i] : -1, i % NUM_FIFO);

        // Case 3: consumer stalled, credit limits pops to 3
        new_phase();
        fill(0, 8);
        begin
            logic [DATA_WIDTH-1:0] first_word;
            first_word = mem[0][head[0]];
            m_ready = 1'b0;
            repeat (12) step();
            check("c3_pops", phase_pops, 3);
            check("c3_fifo_pop", fifo_pop, 0);
            check("c3_m_valid", m_valid, 1);
            check("c3_m_data", m_data, first_word);
            check("c3_m_src", m_src, 0);
        end
        m_ready = 1'b1;
        drain(400, 1'b0);
        check("c3_xfers", phase_xfers, 8);

        // Case 4: short fifo empties mid-burst
        new_phase();
        fill(2, 2);
        m_ready = 1'b1;
        repeat (10) step();
        check("c4_pops", phase_pops, 2);
        check("c4_grant", (grants.size() > 0) ? grants[0] : -1, 2);
        check("c4_busy", busy, 0);
        check("c4_xfers", phase_xfers, 2);

        // Case 5: enable dropped after two pops
        new_phase();
        fill(0, 6);
        m_ready = 1'b1;
        wait_pops(2, 50);
        enable         = 1'b0;
        burst_cnt      = 0;
        last_burst_end = -1;
        repeat (10) step();
        check("c5_pops", phase_pops, 2);
        check("c5_xfers", phase_xfers, 2);
        check("c5_busy", busy, 0);
        enable = 1'b1;
        drain(400, 1'b0);
        check("c5_total", phase_xfers, 6);

        // Case 6: reset the cycle after a pop drops the in-flight word
        do_reset();
        reset = 1'b0;
        new_phase();
        fill(2, 4);
        m_ready = 1'b0;
        wait_pops(1, 50);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("c6_m_valid", m_valid, 0);
        check("c6_busy", busy, 0);
        new_phase();
        fill(0, 2);
        total   = words_left();
        m_ready = 1'b1;
        drain(400, 1'b0);
        check("c6_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        check("c6_xfers", phase_xfers, total);

        // Randomized rounds with random consumer back-pressure
        for (int r = 0; r < 25; r++) begin
            new_phase();
            for (int f = 0; f < NUM_FIFO; f++) fill(f, $urandom_range(0, 9));
            total = words_left();
            drain(2000, 1'b1);
            check($sformatf("rnd%0d_xfers", r), phase_xfers, total);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
